// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the VTA fetch/dispatch stage.
package fetch_pkg;

  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_W    = 3;
  localparam int MEMTYPE_LSB = 7;
  localparam int MEMTYPE_W   = 2;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    STORE  = 3'd1,
    GEMM   = 3'd2,
    FINISH = 3'd3,
    ALU    = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    UOP = 2'd0,
    WGT = 2'd1,
    INP = 2'd2,
    ACC = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    Q_LOAD  = 2'd0,
    Q_GEMM  = 2'd1,
    Q_STORE = 2'd2
  } queue_sel_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_dispatch_if.sv
// Instruction-memory read port plus the three command-queue push ports.
// Queue pushes: valid rises with data, both hold until the cycle ready is also high; that cycle is the transfer.
interface fetch_dispatch_if #(
  parameter int INSN_W = 128,
  parameter int ADDR_W = 10
) ();

  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSN_W-1:0] imem_rdata;

  logic              load_valid;
  logic              load_ready;
  logic [INSN_W-1:0] load_data;

  logic              gemm_valid;
  logic              gemm_ready;
  logic [INSN_W-1:0] gemm_data;

  logic              store_valid;
  logic              store_ready;
  logic [INSN_W-1:0] store_data;

  modport master (
    output imem_rd, imem_addr,
    input  imem_rdata,
    output load_valid, load_data,
    input  load_ready,
    output gemm_valid, gemm_data,
    input  gemm_ready,
    output store_valid, store_data,
    input  store_ready
  );

  modport slave (
    input  imem_rd, imem_addr,
    output imem_rdata,
    input  load_valid, load_data,
    output load_ready,
    input  gemm_valid, gemm_data,
    output gemm_ready,
    input  store_valid, store_data,
    output store_ready
  );

endinterface

// File: rtl/fetch_decode.sv
// Maps one instruction word to the command queue that must receive it.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int INSN_W = 128
) (
  input  logic [INSN_W-1:0] i_insn,
  output queue_sel_t        o_sel
);

  logic [OPCODE_W-1:0]  w_op;
  logic [MEMTYPE_W-1:0] w_mt;
  logic                 w_unused;

  assign w_op     = i_insn[OPCODE_LSB +: OPCODE_W];
  assign w_mt     = i_insn[MEMTYPE_LSB +: MEMTYPE_W];
  assign w_unused = ^{i_insn[INSN_W-1:MEMTYPE_LSB+MEMTYPE_W],
                      i_insn[MEMTYPE_LSB-1:OPCODE_LSB+OPCODE_W]};

  // Everything that is neither STORE nor a WGT/INP load (incl. opcodes 5-7) feeds gemm.
  always_comb begin
    o_sel = Q_GEMM;
    if (w_op == STORE) begin
      o_sel = Q_STORE;
    end else if (w_op == LOAD && (w_mt == WGT || w_mt == INP)) begin
      o_sel = Q_LOAD;
    end
  end

endmodule

// File: rtl/fetch_dispatch.sv
// Fetch sequencer: reads insn_count words from imem and pushes each into the
// load, gemm or store queue, one instruction every three cycles at best.
module fetch_dispatch
  import fetch_pkg::*;
#(
  parameter int INSN_W = 128,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] insn_count,
  output logic             idle,
  output logic             done,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] gemm_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output state_t           state_dbg,
  fetch_dispatch_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_load_cnt;
  logic [CNT_W-1:0]  r_gemm_cnt;
  logic [CNT_W-1:0]  r_store_cnt;
  logic [INSN_W-1:0] r_insn;
  queue_sel_t        r_sel;
  queue_sel_t        w_sel;
  logic              w_ready;
  logic              w_push;
  logic              w_hs;
  logic              w_accept;

  fetch_decode #(.INSN_W(INSN_W)) u_decode (
    .i_insn (bus.imem_rdata),
    .o_sel  (w_sel)
  );

  assign w_push   = (r_state == S_PUSH);
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_ready = 1'b0;
    case (r_sel)
      Q_LOAD:  w_ready = bus.load_ready;
      Q_STORE: w_ready = bus.store_ready;
      default: w_ready = bus.gemm_ready;
    endcase
  end

  assign w_hs = w_push && w_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (insn_count == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  w_next = S_CAPT;
      S_CAPT: w_next = S_PUSH;
      S_PUSH: begin
        if (w_hs) begin
          w_next = (r_remaining == CNT_W'(1)) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_load_cnt  <= '0;
      r_gemm_cnt  <= '0;
      r_store_cnt <= '0;
      r_insn      <= '0;
      r_sel       <= Q_GEMM;
    end else begin
      if (w_accept) begin
        r_remaining <= insn_count;
        r_ptr       <= '0;
        r_load_cnt  <= '0;
        r_gemm_cnt  <= '0;
        r_store_cnt <= '0;
      end
      // imem_rdata is valid only in the cycle after the read; capture word and route together.
      if (r_state == S_CAPT) begin
        r_insn <= bus.imem_rdata;
        r_sel  <= w_sel;
      end
      if (w_hs) begin
        r_ptr       <= r_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        case (r_sel)
          Q_LOAD:  r_load_cnt  <= r_load_cnt + 1'b1;
          Q_STORE: r_store_cnt <= r_store_cnt + 1'b1;
          default: r_gemm_cnt  <= r_gemm_cnt + 1'b1;
        endcase
      end
    end
  end

  assign idle      = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign state_dbg = r_state;
  assign load_cnt  = r_load_cnt;
  assign gemm_cnt  = r_gemm_cnt;
  assign store_cnt = r_store_cnt;

  assign bus.imem_rd   = (r_state == S_REQ);
  assign bus.imem_addr = r_ptr;

  // Data is forced to zero whenever its queue is not being offered a word.
  assign bus.load_valid  = w_push && (r_sel == Q_LOAD);
  assign bus.gemm_valid  = w_push && (r_sel == Q_GEMM);
  assign bus.store_valid = w_push && (r_sel == Q_STORE);
  assign bus.load_data   = bus.load_valid  ? r_insn : '0;
  assign bus.gemm_data   = bus.gemm_valid  ? r_insn : '0;
  assign bus.store_data  = bus.store_valid ? r_insn : '0;

endmodule
